mem_loader: RTL



---
 rtl/mem_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// mem_loader : host command stream -> IMEM/DMEM load, DMEM readback, CPU run
// Revision   : 1.0
// ============================================================================
module mem_loader #(
  parameter logic [7:0] ACK_TAG = 8'hAC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2,
  output logic        enable
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_I    = 3'd1,
    WR_D    = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RD_SEND = 3'd5,
    RUN     = 3'd6,
    ACK     = 3'd7
  } state_t;

  localparam logic [1:0] OP_WR_IMEM = 2'b00;
  localparam logic [1:0] OP_WR_DMEM = 2'b01;
  localparam logic [1:0] OP_RD_DMEM = 2'b10;

  state_t      state, state_next;
  logic [13:0] remaining;
  logic [15:0] word_addr;
  logic        s_fire;
  logic        last;
  logic [1:0]  hdr_op;
  logic [13:0] hdr_cnt;
  logic [15:0] hdr_addr;
  logic        unused_rdata;

  assign unused_rdata = ^rdata_ext;
  assign ren_ext      = 1'b0;

  assign hdr_op   = s_data[31:30];
  assign hdr_cnt  = s_data[29:16];
  assign hdr_addr = s_data[15:0];

  assign s_ready = !rst && (state == IDLE || state == WR_I || state == WR_D);
  assign m_valid = (state == RD_SEND) || (state == ACK);
  assign s_fire  = s_valid && s_ready;
  assign last    = (remaining == 14'd1);

  function automatic logic [31:0] byte_addr(input logic [15:0] w);
    return {14'b0, w, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (s_fire) begin
          case (hdr_op)
            OP_WR_IMEM: state_next = (hdr_cnt == 14'd0) ? IDLE : WR_I;
            OP_WR_DMEM: state_next = (hdr_cnt == 14'd0) ? IDLE : WR_D;
            OP_RD_DMEM: state_next = (hdr_cnt == 14'd0) ? IDLE : RD_REQ;
            default:    state_next = (hdr_cnt == 14'd0) ? ACK  : RUN;
          endcase
        end
      end
      WR_I, WR_D: if (s_fire && last) state_next = IDLE;
      RD_REQ:     state_next = RD_WAIT;
      RD_WAIT:    state_next = RD_SEND;
      RD_SEND:    if (m_ready) state_next = last ? IDLE : RD_REQ;
      RUN:        if (last) state_next = ACK;
      ACK:        if (m_ready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Strobes default low each cycle so every accepted word yields a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining   <= 14'd0;
      word_addr   <= 16'd0;
      m_data      <= 32'd0;
      addr_ext    <= 32'd0;
      wen_ext     <= 1'b0;
      wdata_ext   <= 32'd0;
      addr_ext_2  <= 32'd0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= 32'd0;
      enable      <= 1'b0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      case (state)
        IDLE: begin
          if (s_fire) begin
            remaining <= hdr_cnt;
            if (hdr_op == OP_RD_DMEM && hdr_cnt != 14'd0) begin
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= byte_addr(hdr_addr);
              word_addr  <= hdr_addr + 16'd1;
            end else begin
              word_addr <= hdr_addr;
            end
            if (hdr_op == 2'b11) begin
              m_data <= {ACK_TAG, 10'b0, hdr_cnt};
              enable <= (hdr_cnt != 14'd0);
            end
          end
        end
        WR_I: begin
          if (s_fire) begin
            wen_ext   <= 1'b1;
            addr_ext  <= byte_addr(word_addr);
            wdata_ext <= s_data;
            word_addr <= word_addr + 16'd1;
            remaining <= remaining - 14'd1;
          end
        end
        WR_D: begin
          if (s_fire) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= byte_addr(word_addr);
            wdata_ext_2 <= s_data;
            word_addr   <= word_addr + 16'd1;
            remaining   <= remaining - 14'd1;
          end
        end
        RD_WAIT: m_data <= rdata_ext_2;
        RD_SEND: begin
          if (m_ready && !last) begin
            ren_ext_2  <= 1'b1;
            addr_ext_2 <= byte_addr(word_addr);
            word_addr  <= word_addr + 16'd1;
            remaining  <= remaining - 14'd1;
          end
        end
        RUN: begin
          remaining <= remaining - 14'd1;
          if (last) enable <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
